// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: loads source bytes into the HDLC Tx buffer, starts
// transmission, polls Tx_SC until done/aborted, and shares the HDLC register
// port with a host (the sequencer always wins; the host waits).
module hdlc_tx_sequencer #(
    parameter int MAX_FRAME     = 126,
    parameter int POLL_GAP      = 16,
    parameter int TIMEOUT_POLLS = 255
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       S_Valid,
    input  logic [7:0] S_Data,
    input  logic       S_Last,
    output logic       S_Ready,
    input  logic       Abort_Req,
    input  logic       H_Req,
    input  logic       H_WriteEnable,
    input  logic       H_ReadEnable,
    input  logic [2:0] H_Address,
    input  logic [7:0] H_DataIn,
    output logic       H_Grant,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [2:0] Address,
    output logic [7:0] Data_In,
    input  logic [7:0] DataOut,
    output logic       Busy,
    output logic       FrameDone,
    output logic       FrameAborted,
    output logic       FrameErr,
    output logic [6:0] ByteCount
);
    localparam int         GW        = $clog2(POLL_GAP + 1);
    localparam int         PW        = $clog2(TIMEOUT_POLLS + 1);
    localparam logic [7:0] MAXF      = 8'(MAX_FRAME);
    localparam logic [2:0] A_SC      = 3'd0;
    localparam logic [2:0] A_BUFF    = 3'd1;
    localparam logic [7:0] SC_ENABLE = 8'h02;
    localparam logic [7:0] SC_ABORT  = 8'h04;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, GAP, POLL_RD, POLL_CHK, ABORT, DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          err_q, err_d;       // frame ends as FrameErr
    logic          pend_q, pend_d;     // abort requested while polling
    logic          labort_q, labort_d; // abort requested while loading
    logic          done_q, done_d, abt_q, abt_d, ferr_q, ferr_d;
    logic          seq_we, seq_re, s_rdy, host_gnt;
    logic [2:0]    seq_addr;
    logic [7:0]    seq_data;
    logic [7:0]    cnt_inc;
    logic          unused_status;

    assign cnt_inc = {1'b0, cnt_q} + 8'd1;
    // Tx_SC bits the sequencer does not act on (Tx_Full, reserved)
    assign unused_status = ^{DataOut[7:4], DataOut[2:1]};

    // State and counter registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            poll_q   <= '0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
            labort_q <= 1'b0;
            done_q   <= 1'b0;
            abt_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            poll_q   <= poll_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
            labort_q <= labort_d;
            done_q   <= done_d;
            abt_q    <= abt_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic and sequencer-side register accesses
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        poll_d   = poll_q;
        err_d    = err_q;
        pend_d   = pend_q;
        labort_d = labort_q;
        done_d   = 1'b0;
        abt_d    = 1'b0;
        ferr_d   = 1'b0;
        seq_we   = 1'b0;
        seq_re   = 1'b0;
        seq_addr = A_SC;
        seq_data = 8'h00;
        s_rdy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (S_Valid) begin
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    pend_d   = 1'b0;
                    labort_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                s_rdy = 1'b1;
                if (S_Valid) begin
                    if (cnt_inc > MAXF) begin
                        // buffer full: drop the byte and fail the frame
                        err_d   = 1'b1;
                        state_d = S_Last ? ABORT : DRAIN;
                    end else begin
                        seq_we   = 1'b1;
                        seq_addr = A_BUFF;
                        seq_data = S_Data;
                        cnt_d    = cnt_inc[6:0];
                        if (Abort_Req) begin
                            labort_d = 1'b1;
                            state_d  = S_Last ? ABORT : DRAIN;
                        end else if (S_Last) begin
                            state_d = START;
                        end
                    end
                end else if (Abort_Req) begin
                    labort_d = 1'b1;
                    state_d  = DRAIN;
                end
            end
            START: begin
                seq_we   = 1'b1;
                seq_data = SC_ENABLE;
                poll_d   = '0;
                gap_d    = '0;
                pend_d   = 1'b0;
                state_d  = (Abort_Req || pend_q) ? ABORT : GAP;
            end
            GAP: begin
                if (Abort_Req) pend_d = 1'b1;
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = POLL_RD;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            POLL_RD: begin
                seq_re  = 1'b1;
                poll_d  = poll_q + PW'(1);
                if (Abort_Req) pend_d = 1'b1;
                state_d = POLL_CHK;
            end
            POLL_CHK: begin
                gap_d  = '0;
                pend_d = 1'b0;
                if (DataOut[3]) begin
                    abt_d   = 1'b1;
                    state_d = IDLE;
                end else if (DataOut[0]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (poll_q == PW'(TIMEOUT_POLLS)) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end else if (pend_q || Abort_Req) begin
                    state_d = ABORT;
                end else begin
                    state_d = GAP;
                end
            end
            ABORT: begin
                seq_we   = 1'b1;
                seq_data = SC_ABORT;
                gap_d    = '0;
                if (err_q) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else if (labort_q) begin
                    abt_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    // user abort while polling: wait for Tx_AbortedTrans
                    state_d = GAP;
                end
            end
            DRAIN: begin
                s_rdy = 1'b1;
                if (S_Valid && S_Last) state_d = ABORT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus arbitration: host gets the port only in cycles the sequencer leaves free
    assign host_gnt     = H_Req && !(seq_we || seq_re) && !Rst;
    assign H_Grant      = host_gnt;
    assign WriteEnable  = seq_we || (host_gnt && H_WriteEnable);
    assign ReadEnable   = seq_re || (host_gnt && H_ReadEnable && !H_WriteEnable);
    assign Address      = (seq_we || seq_re) ? seq_addr : (host_gnt ? H_Address : 3'd0);
    assign Data_In      = seq_we ? seq_data : (host_gnt ? H_DataIn : 8'h00);
    assign S_Ready      = s_rdy;
    assign Busy         = (state_q != IDLE);
    assign FrameDone    = done_q;
    assign FrameAborted = abt_q;
    assign FrameErr     = ferr_q;
    assign ByteCount    = cnt_q;
endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Bench for hdlc_tx_sequencer: HDLC register model, bus monitor, table of
// directed frames, a reset-in-LOAD sequence, and randomized frames.
module tb_hdlc_tx_sequencer;
    localparam int MAX_FRAME     = 126;
    localparam int POLL_GAP      = 16;
    localparam int TIMEOUT_POLLS = 255;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       S_Valid = 1'b0;
    logic [7:0] S_Data = 8'h00;
    logic       S_Last = 1'b0;
    logic       S_Ready;
    logic       Abort_Req = 1'b0;
    logic       H_Req = 1'b0;
    logic       H_WriteEnable = 1'b0;
    logic       H_ReadEnable = 1'b1;
    logic [2:0] H_Address = 3'd3;
    logic [7:0] H_DataIn = 8'h00;
    logic       H_Grant, WriteEnable, ReadEnable;
    logic [2:0] Address;
    logic [7:0] Data_In;
    logic [7:0] DataOut = 8'h00;
    logic       Busy, FrameDone, FrameAborted, FrameErr;
    logic [6:0] ByteCount;

    hdlc_tx_sequencer #(.MAX_FRAME(MAX_FRAME), .POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TIMEOUT_POLLS)) dut (
        .Clk(Clk), .Rst(Rst), .S_Valid(S_Valid), .S_Data(S_Data), .S_Last(S_Last),
        .S_Ready(S_Ready), .Abort_Req(Abort_Req), .H_Req(H_Req),
        .H_WriteEnable(H_WriteEnable), .H_ReadEnable(H_ReadEnable),
        .H_Address(H_Address), .H_DataIn(H_DataIn), .H_Grant(H_Grant),
        .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .Address(Address),
        .Data_In(Data_In), .DataOut(DataOut), .Busy(Busy), .FrameDone(FrameDone),
        .FrameAborted(FrameAborted), .FrameErr(FrameErr), .ByteCount(ByteCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         we;
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } txn_t;

    // abort_kind: 0 none, 1 Abort_Req with byte abort_idx, 2 Abort_Req during GAP
    // exp_res: 0 FrameDone, 1 FrameAborted, 2 FrameErr
    typedef struct {
        int len;
        int done_after;
        int abort_kind;
        int abort_idx;
        int host_mode;
        int gaps;
        int exp_reads;
        int exp_res;
        int exp_bc;
    } vec_t;

    txn_t       log_q[$];
    txn_t       exp_q[$];
    logic [7:0] frame_q[$];
    int cyc = 0, done_cnt = 0, abt_cnt = 0, err_cnt = 0, bus_err = 0, grant_cnt = 0;
    int m_polls = 0;
    bit m_aborted = 1'b0, prev_rd = 1'b0, last_grant = 1'b0;
    int cfg_done_after = 0;
    int host_mode = 0;
    int vectors = 0, miscompares = 0;

    // Monitor + HDLC register model: logs sequencer-owned accesses, checks
    // arbitration, answers Tx_SC reads (data held for the following cycle).
    always @(negedge Clk) begin
        txn_t t;
        bit   sq_we, sq_re;
        cyc++;
        sq_we = WriteEnable && !H_Grant;
        sq_re = ReadEnable && !H_Grant;
        if (WriteEnable && ReadEnable) bus_err++;
        if (H_Grant) begin
            grant_cnt++;
            if (!H_Req || WriteEnable !== H_WriteEnable || ReadEnable !== H_ReadEnable ||
                Address !== H_Address) bus_err++;
        end else if (H_Req && !Rst && !sq_we && !sq_re) begin
            bus_err++;
        end
        if (sq_we || sq_re) begin
            t.we = sq_we; t.addr = Address; t.data = sq_we ? Data_In : 8'h00; t.cyc = cyc;
            log_q.push_back(t);
        end
        if (sq_we && Address == 3'd0 && Data_In == 8'h02) begin m_polls = 0; m_aborted = 1'b0; end
        if (sq_we && Address == 3'd0 && Data_In == 8'h04) m_aborted = 1'b1;
        if (sq_re && Address == 3'd0) begin
            m_polls++;
            DataOut = {4'b0000, m_aborted, 2'b00, (cfg_done_after != 0 && m_polls >= cfg_done_after)};
            prev_rd = 1'b1;
        end else begin
            if (!prev_rd) DataOut = 8'h00;
            prev_rd = 1'b0;
        end
        if (FrameDone) done_cnt++;
        if (FrameAborted) abt_cnt++;
        if (FrameErr) err_cnt++;
        last_grant = H_Grant;
    end

    // Host requester: 0 idle, 1 request every cycle, 2 random but held until granted
    always @(posedge Clk) begin
        #1;
        case (host_mode)
            0:       H_Req = 1'b0;
            1:       H_Req = 1'b1;
            default: if (!(H_Req && !last_grant)) H_Req = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit abt);
        bit acc;
        int guard = 0;
        S_Valid = 1'b1; S_Data = d; S_Last = last; Abort_Req = abt;
        do begin
            @(negedge Clk);
            acc = S_Ready;
            @(posedge Clk); #1;
            Abort_Req = 1'b0;
            guard++;
        end while (!acc && guard < 50);
        S_Valid = 1'b0; S_Last = 1'b0;
        if (!acc) chk("accept", 0, 1);
    endtask

    // Expected sequencer register traffic, from the frame-level rules
    task automatic build_exp(input vec_t v);
        int   nw;
        txn_t t;
        exp_q.delete();
        t.cyc = 0;
        nw = (v.abort_kind == 1) ? v.abort_idx + 1 : ((v.len > MAX_FRAME) ? MAX_FRAME : v.len);
        for (int i = 0; i < nw; i++) begin
            t.we = 1'b1; t.addr = 3'd1; t.data = frame_q[i]; exp_q.push_back(t);
        end
        if (v.abort_kind == 1 || v.len > MAX_FRAME) begin
            t.we = 1'b1; t.addr = 3'd0; t.data = 8'h04; exp_q.push_back(t);
        end else begin
            t.we = 1'b1; t.addr = 3'd0; t.data = 8'h02; exp_q.push_back(t);
            if (v.abort_kind == 2) begin
                t.we = 1'b0; t.data = 8'h00; exp_q.push_back(t);
                t.we = 1'b1; t.data = 8'h04; exp_q.push_back(t);
                t.we = 1'b0; t.data = 8'h00; exp_q.push_back(t);
            end else if (v.done_after == 0) begin
                t.we = 1'b0; t.data = 8'h00;
                for (int i = 0; i < TIMEOUT_POLLS; i++) exp_q.push_back(t);
                t.we = 1'b1; t.data = 8'h04; exp_q.push_back(t);
            end else begin
                t.we = 1'b0; t.data = 8'h00;
                for (int i = 0; i < v.done_after; i++) exp_q.push_back(t);
            end
        end
    endtask

    task automatic run_case(input vec_t v, input string nm);
        int  start_idx, d0, a0, e0, b0, g0, guard, mism, reads, min_gap, prev_c;
        bit  seen;
        cfg_done_after = v.done_after;
        host_mode = v.host_mode;
        start_idx = log_q.size();
        d0 = done_cnt; a0 = abt_cnt; e0 = err_cnt; b0 = bus_err; g0 = grant_cnt;
        build_exp(v);
        for (int i = 0; i < v.len; i++) begin
            if (v.gaps > 0) tick($urandom_range(0, v.gaps));
            send_byte(frame_q[i], i == v.len - 1, v.abort_kind == 1 && i == v.abort_idx);
        end
        if (v.abort_kind == 2) begin
            seen = 1'b0; guard = 0;
            while (!seen && guard < 500) begin
                for (int i = start_idx; i < log_q.size(); i++)
                    if (log_q[i].we && log_q[i].addr == 3'd0 && log_q[i].data == 8'h02) seen = 1'b1;
                if (!seen) begin tick(1); guard++; end
            end
            chk({nm, " start_seen"}, seen, 1);
            tick(3);
            Abort_Req = 1'b1;
            tick(1);
            Abort_Req = 1'b0;
        end
        guard = 0;
        while ((done_cnt + abt_cnt + err_cnt) == (d0 + a0 + e0) && guard < 8000) begin
            tick(1); guard++;
        end
        chk({nm, " finished_in_time"}, guard < 8000, 1);
        tick(2);
        host_mode = 0;
        chk({nm, " seq_len"}, log_q.size() - start_idx, exp_q.size());
        mism = 0; reads = 0; min_gap = 1000000; prev_c = -1;
        for (int i = 0; i < exp_q.size() && start_idx + i < log_q.size(); i++) begin
            txn_t a;
            a = log_q[start_idx + i];
            if (a.we !== exp_q[i].we || a.addr !== exp_q[i].addr || a.data !== exp_q[i].data) begin
                if (mism == 0)
                    $display("FAIL %s seq[%0d]: got we=%0d addr=%0d data=%02h expected we=%0d addr=%0d data=%02h",
                             nm, i, a.we, a.addr, a.data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
                mism++;
            end
        end
        for (int i = start_idx; i < log_q.size(); i++) begin
            if (!log_q[i].we) begin
                reads++;
                if (prev_c >= 0 && log_q[i].cyc - prev_c < min_gap) min_gap = log_q[i].cyc - prev_c;
                prev_c = log_q[i].cyc;
            end
        end
        chk({nm, " seq_content_errors"}, mism, 0);
        chk({nm, " status_reads"}, reads, v.exp_reads);
        if (reads >= 2) chk({nm, " read_spacing_ok"}, min_gap >= POLL_GAP + 1, 1);
        chk({nm, " result_pulses"}, (done_cnt - d0) * 100 + (abt_cnt - a0) * 10 + (err_cnt - e0),
            (v.exp_res == 0) ? 100 : ((v.exp_res == 1) ? 10 : 1));
        chk({nm, " ByteCount"}, ByteCount, v.exp_bc);
        chk({nm, " Busy"}, Busy, 0);
        chk({nm, " bus_errors"}, bus_err - b0, 0);
        if (v.host_mode != 0) chk({nm, " host_granted"}, (grant_cnt - g0) > 0, 1);
    endtask

    task automatic rand_frame(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        tbl[0] = '{3,   5, 0, 0, 0, 0, 5,   0, 3};   // basic 3-byte frame
        tbl[1] = '{130, 1, 0, 0, 0, 0, 0,   2, 126}; // overflow, last on byte 130
        tbl[2] = '{1,   0, 0, 0, 0, 0, 255, 2, 1};   // Tx_Done never set
        tbl[3] = '{2,   0, 2, 0, 0, 0, 2,   1, 2};   // abort during GAP
        tbl[4] = '{4,   2, 0, 0, 1, 1, 2,   0, 4};   // host requesting every cycle
        tbl[5] = '{126, 1, 0, 0, 0, 0, 1,   0, 126}; // largest legal frame
        tbl[6] = '{5,   0, 1, 2, 0, 0, 0,   1, 3};   // abort while loading

        // reset state, with source and host both asserting
        S_Valid = 1'b1; host_mode = 1;
        tick(2);
        chk("reset_outputs", {S_Ready, H_Grant, WriteEnable, ReadEnable, Address, Data_In,
                              Busy, FrameDone, FrameAborted, FrameErr, ByteCount}, 0);
        S_Valid = 1'b0; host_mode = 0;
        tick(1);
        Rst = 1'b0;
        tick(2);

        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                frame_q.delete();
                frame_q.push_back(8'hAA); frame_q.push_back(8'h55); frame_q.push_back(8'h0F);
            end else begin
                rand_frame(tbl[k].len);
            end
            run_case(tbl[k], $sformatf("vec%0d", k));
            tick(3);
        end

        // reset in the middle of LOAD, then a fresh 1-byte frame
        cfg_done_after = 1;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        S_Valid = 1'b1; S_Data = 8'h33; host_mode = 1;
        Rst = 1'b1;
        #1;
        chk("midload_reset_outputs", {S_Ready, H_Grant, WriteEnable, ReadEnable, Address, Data_In,
                                      Busy, FrameDone, FrameAborted, FrameErr, ByteCount}, 0);
        S_Valid = 1'b0; host_mode = 0;
        tick(2);
        Rst = 1'b0;
        tick(2);
        rand_frame(1);
        v = '{1, 1, 0, 0, 0, 0, 1, 0, 1};
        run_case(v, "after_reset");
        tick(3);

        // randomized frames with a random, request-holding host
        for (int r = 0; r < 6; r++) begin
            v.len        = $urandom_range(1, 40);
            v.abort_kind = ($urandom_range(0, 3) == 0) ? 2 : 0;
            v.done_after = (v.abort_kind == 2) ? $urandom_range(2, 6) : $urandom_range(1, 6);
            v.abort_idx  = 0;
            v.host_mode  = 2;
            v.gaps       = 2;
            v.exp_reads  = (v.abort_kind == 2) ? 2 : v.done_after;
            v.exp_res    = (v.abort_kind == 2) ? 1 : 0;
            v.exp_bc     = v.len;
            rand_frame(v.len);
            run_case(v, $sformatf("rand%0d", r));
            tick(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
